// File: rtl/kid_motion_ctrl.sv
// kid_motion_ctrl: per-frame motion sequencer for the player sprite.
// Drives planned moves to wall collision logic, then commits corrections.
module kid_motion_ctrl #(
  parameter int START_X   = 40,
  parameter int START_Y   = 100,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 620,
  parameter int WALK_V    = 3,
  parameter int JUMP_V    = 8,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 8,
  parameter int AIR_JUMPS = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       hit_y,
  input  logic       hit_top,
  input  logic       Ground,
  input  logic [9:0] Kid_position_Y_hit,
  input  logic [9:0] Kid_position_Y_top,
  output logic [9:0] Kid_position_X,
  output logic [9:0] Kid_position_Y,
  output logic [9:0] Kid_move_X,
  output logic [9:0] Kid_move_Y,
  output logic [1:0] kid_state,
  output logic       facing_left
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } kstate_t;

  typedef enum logic [1:0] {
    S_WAIT,
    S_APPLY,
    S_PLAN
  } seq_t;

  localparam logic signed [9:0]  GRAV = 10'(GRAVITY);
  localparam logic signed [9:0]  JV   = 10'(JUMP_V);
  localparam logic signed [9:0]  MF   = 10'(MAX_FALL);
  localparam logic signed [10:0] WV   = 11'(WALK_V);
  localparam logic signed [10:0] XMIN = 11'(X_MIN);
  localparam logic signed [10:0] XMAX = 11'(X_MAX);
  localparam logic [3:0]         AJ   = 4'(AIR_JUMPS);

  seq_t             seq;
  kstate_t          st;
  kstate_t          nst;
  logic signed [9:0] vy;
  logic signed [9:0] nvy;
  logic signed [9:0] rise_v;
  logic signed [9:0] fall_v;
  logic [3:0]       jl;
  logic [3:0]       njl;
  logic             jump_req;
  logic             frame_d;
  logic             jump_d;
  logic             tick;
  logic             jrise;
  logic signed [10:0] raw;
  logic signed [10:0] px;
  logic signed [10:0] sx;
  logic signed [10:0] mvx;
  logic             nface;

  assign tick      = frame_clk & ~frame_d;
  assign jrise     = key_jump & ~jump_d;
  assign kid_state = st;

  // Vertical plan: jump grant, rise decay with jump release, capped fall.
  always_comb begin
    nst    = st;
    nvy    = vy;
    njl    = jl;
    rise_v = key_jump ? (vy + GRAV) : ((vy >>> 1) + GRAV);
    fall_v = vy + GRAV;
    if (jump_req && (st == GROUND || jl != 4'd0)) begin
      nvy = -JV;
      nst = RISE;
      if (st != GROUND) njl = jl - 4'd1;
    end else begin
      unique case (st)
        RISE: begin
          nvy = rise_v;
          if (!rise_v[9]) nst = FALL;
        end
        FALL:    nvy = (fall_v > MF) ? MF : fall_v;
        default: nvy = '0;
      endcase
    end
  end

  // Horizontal plan: walk speed clamped to the legal X window.
  always_comb begin
    raw   = '0;
    nface = facing_left;
    unique case (1'b1)
      (key_right && !key_left): begin
        raw   = WV;
        nface = 1'b0;
      end
      (key_left && !key_right): begin
        raw   = -WV;
        nface = 1'b1;
      end
      default: raw = '0;
    endcase
    px  = $signed({1'b0, Kid_position_X});
    sx  = px + raw;
    mvx = raw;
    if (sx > XMAX)      mvx = XMAX - px;
    else if (sx < XMIN) mvx = XMIN - px;
  end

  // Frame sequencer: wait for tick, apply collision result, plan next move.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      seq            <= S_WAIT;
      st             <= FALL;
      vy             <= '0;
      jl             <= AJ;
      jump_req       <= 1'b0;
      frame_d        <= 1'b0;
      jump_d         <= key_jump;
      Kid_position_X <= 10'(START_X);
      Kid_position_Y <= 10'(START_Y);
      Kid_move_X     <= '0;
      Kid_move_Y     <= '0;
      facing_left    <= 1'b0;
    end else begin
      frame_d <= frame_clk;
      jump_d  <= key_jump;
      if (jrise) jump_req <= 1'b1;
      unique case (seq)
        S_WAIT: begin
          if (tick) seq <= S_APPLY;
        end
        S_APPLY: begin
          seq            <= S_PLAN;
          Kid_position_X <= Kid_position_X + Kid_move_X;
          if (hit_y) begin
            Kid_position_Y <= Kid_position_Y_hit;
            vy             <= '0;
            st             <= GROUND;
            jl             <= AJ;
          end else if (hit_top) begin
            Kid_position_Y <= Kid_position_Y_top;
            vy             <= '0;
            st             <= FALL;
          end else if (st == GROUND && !Ground) begin
            st <= FALL;
          end else begin
            Kid_position_Y <= Kid_position_Y + Kid_move_Y;
          end
        end
        S_PLAN: begin
          seq         <= S_WAIT;
          jump_req    <= jrise;
          vy          <= nvy;
          st          <= nst;
          jl          <= njl;
          Kid_move_Y  <= nvy;
          Kid_move_X  <= mvx[9:0];
          facing_left <= nface;
        end
        default: seq <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_kid_motion_ctrl.sv
// tb_kid_motion_ctrl: directed checks of the kid motion controller.
// Each task drives one scenario and compares outputs inline.
module tb_kid_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_jump = 1'b0;
  logic       hit_y = 1'b0;
  logic       hit_top = 1'b0;
  logic       Ground = 1'b0;
  logic [9:0] Kid_position_Y_hit = '0;
  logic [9:0] Kid_position_Y_top = '0;
  logic [9:0] Kid_position_X;
  logic [9:0] Kid_position_Y;
  logic [9:0] Kid_move_X;
  logic [9:0] Kid_move_Y;
  logic [1:0] kid_state;
  logic       facing_left;

  int compared = 0;
  int mismatched = 0;

  kid_motion_ctrl dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .key_left(key_left),
    .key_right(key_right),
    .key_jump(key_jump),
    .hit_y(hit_y),
    .hit_top(hit_top),
    .Ground(Ground),
    .Kid_position_Y_hit(Kid_position_Y_hit),
    .Kid_position_Y_top(Kid_position_Y_top),
    .Kid_position_X(Kid_position_X),
    .Kid_position_Y(Kid_position_Y),
    .Kid_move_X(Kid_move_X),
    .Kid_move_Y(Kid_move_Y),
    .kid_state(kid_state),
    .facing_left(facing_left)
  );

  always #5 Clk = ~Clk;

  task automatic do_frame;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    compared++;
    if (Kid_position_X !== 10'd40) begin
      mismatched++;
      $display("FAIL rst_x got %0d want 40", Kid_position_X);
    end
    compared++;
    if (Kid_position_Y !== 10'd100) begin
      mismatched++;
      $display("FAIL rst_y got %0d want 100", Kid_position_Y);
    end
    compared++;
    if (Kid_move_X !== 10'd0 || Kid_move_Y !== 10'd0) begin
      mismatched++;
      $display("FAIL rst_move got %0h/%0h want 0/0", Kid_move_X, Kid_move_Y);
    end
    compared++;
    if (kid_state !== 2'd2 || facing_left !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_state got %0d/%0b want 2/0", kid_state, facing_left);
    end
    repeat (6) @(negedge Clk);
    compared++;
    if (Kid_position_Y !== 10'd100 || Kid_move_Y !== 10'd0) begin
      mismatched++;
      $display("FAIL rst_idle got y=%0d my=%0h want 100/0", Kid_position_Y, Kid_move_Y);
    end
  endtask

  task automatic test_free_fall;
    logic [9:0] mv [10];
    logic [9:0] ey;
    mv = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd8, 10'd8};
    ey = 10'd100;
    Ground = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_frame();
      compared++;
      if (Kid_move_Y !== mv[i] || Kid_position_Y !== ey) begin
        mismatched++;
        $display("FAIL fall_%0d got y=%0d my=%0d want y=%0d my=%0d", i, Kid_position_Y, Kid_move_Y, ey, mv[i]);
      end
      ey = ey + mv[i];
    end
  endtask

  task automatic test_landing;
    hit_y = 1'b1;
    Kid_position_Y_hit = 10'd416;
    do_frame();
    hit_y = 1'b0;
    compared++;
    if (Kid_position_Y !== 10'd416 || Kid_move_Y !== 10'd0 || kid_state !== 2'd0) begin
      mismatched++;
      $display("FAIL land got y=%0d my=%0h st=%0d want 416/0/0", Kid_position_Y, Kid_move_Y, kid_state);
    end
    Ground = 1'b1;
    do_frame();
    compared++;
    if (Kid_position_Y !== 10'd416 || kid_state !== 2'd0) begin
      mismatched++;
      $display("FAIL land_hold got y=%0d st=%0d want 416/0", Kid_position_Y, kid_state);
    end
  endtask

  task automatic test_double_jump;
    key_jump = 1'b1;
    do_frame();
    compared++;
    if (Kid_move_Y !== 10'h3F8 || kid_state !== 2'd1) begin
      mismatched++;
      $display("FAIL jump1 got my=%0h st=%0d want 3f8/1", Kid_move_Y, kid_state);
    end
    Ground = 1'b0;
    do_frame();
    compared++;
    if (Kid_position_Y !== 10'd408 || Kid_move_Y !== 10'h3F9) begin
      mismatched++;
      $display("FAIL rise1 got y=%0d my=%0h want 408/3f9", Kid_position_Y, Kid_move_Y);
    end
    do_frame();
    compared++;
    if (Kid_position_Y !== 10'd401 || Kid_move_Y !== 10'h3FA) begin
      mismatched++;
      $display("FAIL rise2 got y=%0d my=%0h want 401/3fa", Kid_position_Y, Kid_move_Y);
    end
    key_jump = 1'b0;
    @(negedge Clk) key_jump = 1'b1;
    do_frame();
    compared++;
    if (Kid_position_Y !== 10'd395 || Kid_move_Y !== 10'h3F8 || kid_state !== 2'd1) begin
      mismatched++;
      $display("FAIL jump2 got y=%0d my=%0h st=%0d want 395/3f8/1", Kid_position_Y, Kid_move_Y, kid_state);
    end
    key_jump = 1'b0;
    @(negedge Clk) key_jump = 1'b1;
    do_frame();
    compared++;
    if (Kid_position_Y !== 10'd387 || Kid_move_Y !== 10'h3F9) begin
      mismatched++;
      $display("FAIL jump3 got y=%0d my=%0h want 387/3f9", Kid_position_Y, Kid_move_Y);
    end
  endtask

  task automatic test_head_hit;
    do_frame();
    compared++;
    if (Kid_position_Y !== 10'd380 || Kid_move_Y !== 10'h3FA) begin
      mismatched++;
      $display("FAIL pre_hit got y=%0d my=%0h want 380/3fa", Kid_position_Y, Kid_move_Y);
    end
    hit_top = 1'b1;
    Kid_position_Y_top = 10'd404;
    do_frame();
    hit_top = 1'b0;
    compared++;
    if (Kid_position_Y !== 10'd404 || Kid_move_Y !== 10'd1 || kid_state !== 2'd2) begin
      mismatched++;
      $display("FAIL head_hit got y=%0d my=%0h st=%0d want 404/1/2", Kid_position_Y, Kid_move_Y, kid_state);
    end
  endtask

  task automatic test_release;
    key_jump = 1'b0;
    hit_y = 1'b1;
    Kid_position_Y_hit = 10'd416;
    do_frame();
    hit_y = 1'b0;
    Ground = 1'b1;
    key_jump = 1'b1;
    do_frame();
    compared++;
    if (Kid_move_Y !== 10'h3F8 || kid_state !== 2'd1) begin
      mismatched++;
      $display("FAIL rel_jump got my=%0h st=%0d want 3f8/1", Kid_move_Y, kid_state);
    end
    Ground = 1'b0;
    do_frame();
    do_frame();
    compared++;
    if (Kid_move_Y !== 10'h3FA) begin
      mismatched++;
      $display("FAIL rel_pre got my=%0h want 3fa", Kid_move_Y);
    end
    key_jump = 1'b0;
    do_frame();
    compared++;
    if (Kid_move_Y !== 10'h3FE || kid_state !== 2'd1) begin
      mismatched++;
      $display("FAIL rel_cut got my=%0h st=%0d want 3fe/1", Kid_move_Y, kid_state);
    end
    do_frame();
    compared++;
    if (Kid_move_Y !== 10'd0 || kid_state !== 2'd2) begin
      mismatched++;
      $display("FAIL rel_apex got my=%0h st=%0d want 0/2", Kid_move_Y, kid_state);
    end
  endtask

  task automatic test_walk;
    hit_y = 1'b1;
    Kid_position_Y_hit = 10'd416;
    key_left = 1'b1;
    do_frame();
    compared++;
    if (Kid_position_X !== 10'd40 || Kid_move_X !== 10'h3FD || facing_left !== 1'b1) begin
      mismatched++;
      $display("FAIL walk_l got x=%0d mx=%0h f=%0b want 40/3fd/1", Kid_position_X, Kid_move_X, facing_left);
    end
    repeat (13) do_frame();
    compared++;
    if (Kid_position_X !== 10'd1 || Kid_move_X !== 10'h3FF) begin
      mismatched++;
      $display("FAIL clamp_l got x=%0d mx=%0h want 1/3ff", Kid_position_X, Kid_move_X);
    end
    do_frame();
    compared++;
    if (Kid_position_X !== 10'd0 || Kid_move_X !== 10'd0) begin
      mismatched++;
      $display("FAIL edge_l got x=%0d mx=%0h want 0/0", Kid_position_X, Kid_move_X);
    end
    key_left = 1'b0;
    key_right = 1'b1;
    do_frame();
    compared++;
    if (Kid_move_X !== 10'd3 || facing_left !== 1'b0) begin
      mismatched++;
      $display("FAIL walk_r got mx=%0h f=%0b want 3/0", Kid_move_X, facing_left);
    end
    repeat (206) do_frame();
    compared++;
    if (Kid_position_X !== 10'd618 || Kid_move_X !== 10'd2) begin
      mismatched++;
      $display("FAIL clamp_r got x=%0d mx=%0h want 618/2", Kid_position_X, Kid_move_X);
    end
    do_frame();
    compared++;
    if (Kid_position_X !== 10'd620 || Kid_move_X !== 10'd0) begin
      mismatched++;
      $display("FAIL edge_r got x=%0d mx=%0h want 620/0", Kid_position_X, Kid_move_X);
    end
    key_right = 1'b0;
    key_left = 1'b1;
    do_frame();
    compared++;
    if (Kid_move_X !== 10'h3FD || facing_left !== 1'b1) begin
      mismatched++;
      $display("FAIL back_l got mx=%0h f=%0b want 3fd/1", Kid_move_X, facing_left);
    end
    key_right = 1'b1;
    do_frame();
    compared++;
    if (Kid_position_X !== 10'd617 || Kid_move_X !== 10'd0 || facing_left !== 1'b1) begin
      mismatched++;
      $display("FAIL both got x=%0d mx=%0h f=%0b want 617/0/1", Kid_position_X, Kid_move_X, facing_left);
    end
    key_left = 1'b0;
    key_right = 1'b0;
    hit_y = 1'b0;
  endtask

  task automatic test_reset_mid;
    Ground = 1'b0;
    @(negedge Clk) key_jump = 1'b1;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    compared++;
    if (Kid_position_X !== 10'd40 || Kid_position_Y !== 10'd100 || kid_state !== 2'd2 || facing_left !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_rst got x=%0d y=%0d st=%0d f=%0b want 40/100/2/0", Kid_position_X, Kid_position_Y, kid_state, facing_left);
    end
    do_frame();
    compared++;
    if (Kid_move_Y !== 10'd1 || kid_state !== 2'd2) begin
      mismatched++;
      $display("FAIL mid_drop got my=%0h st=%0d want 1/2", Kid_move_Y, kid_state);
    end
    key_jump = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_fall();
    test_landing();
    test_double_jump();
    test_head_hit();
    test_release();
    test_walk();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
